// File: rtl/enc_pkg.sv
// Shared definitions for the one-hot event encoder: default sizing and the
// output-slot state type used by the top level.
package enc_pkg;

    localparam int N_IN_DEFAULT  = 16;
    localparam int IDX_W_DEFAULT = 4;

    // Output slot: EMPTY means nothing presented, FULL means out_idx is valid.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage : enc_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the lowest set bit of vec at or
// above ptr, wrapping from the top index back to 0.
module rr_pick
    import enc_pkg::*;
#(
    parameter int N_IN  = N_IN_DEFAULT,
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic [N_IN-1:0]  vec,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    localparam int SUM_W = IDX_W + 1;

    // rot[j] is vec viewed from ptr: rot[j] = vec[(ptr + j) mod N_IN].
    // pos[j] is the absolute index that rot[j] came from.
    logic [N_IN-1:0]  rot;
    logic [IDX_W-1:0] pos [N_IN];

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_rot
        logic [SUM_W-1:0] sum;
        assign sum     = {1'b0, ptr} + SUM_W'(gi);
        assign pos[gi] = (sum >= SUM_W'(N_IN)) ? IDX_W'(sum - SUM_W'(N_IN))
                                               : IDX_W'(sum);
        assign rot[gi] = vec[pos[gi]];
    end

    // Priority search over the rotated view; scanning downwards lets the
    // smallest offset from ptr overwrite any later candidate.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int j = N_IN - 1; j >= 0; j--) begin
            if (rot[j]) begin
                any = 1'b1;
                idx = pos[j];
            end
        end
    end

endmodule : rr_pick

// File: rtl/event_encoder_16x4.sv
// One-hot event encoder: captures event strobes into a pending set, serves
// them round-robin through a single-entry valid/ready output slot and flags
// events that were merged into an already-pending bit.
module event_encoder_16x4
    import enc_pkg::*;
#(
    parameter int N_IN  = N_IN_DEFAULT,
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_IN-1:0]  req,
    input  logic             out_ready,
    input  logic             clr_ovf,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_IN-1:0]  pending,
    output logic             overflow
);

    slot_state_t      state_q, state_d;
    logic [N_IN-1:0]  pending_q, pending_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             overflow_q, overflow_d;

    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;

    logic             xfer;
    logic             load;
    logic [N_IN-1:0]  capture;
    logic [N_IN-1:0]  clear_mask;
    logic             ovf_event;

    rr_pick #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_pick (
        .vec (pending_q),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Next-state logic for the pending set, slot, pointer and overflow flag.
    always_comb begin
        xfer       = (state_q == FULL) && out_ready;
        load       = ((state_q == EMPTY) || xfer) && pick_any;
        capture    = en ? req : '0;
        clear_mask = load ? (N_IN'(1) << pick_idx) : '0;

        // A new strobe on a bit being served this edge re-arms it (set wins)
        // and is not a loss; a strobe on any other pending bit is merged away.
        ovf_event  = |(capture & pending_q & ~clear_mask);
        pending_d  = (pending_q & ~clear_mask) | capture;

        overflow_d = overflow_q;
        if (ovf_event) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        state_d   = state_q;
        out_idx_d = out_idx_q;
        ptr_d     = ptr_q;
        if (load) begin
            state_d   = FULL;
            out_idx_d = pick_idx;
            ptr_d     = (pick_idx == IDX_W'(N_IN - 1)) ? '0 : pick_idx + 1'b1;
        end else if (xfer) begin
            state_d   = EMPTY;
        end
    end

    // State registers; reset clears everything, dropping any unserved events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            pending_q  <= '0;
            ptr_q      <= '0;
            out_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            ptr_q      <= ptr_d;
            out_idx_q  <= out_idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule : event_encoder_16x4

// File: tb/tb_event_encoder_16x4.sv
// Self-checking bench for event_encoder_16x4: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_event_encoder_16x4;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic        out_ready;
    logic        clr_ovf;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic [15:0] pending;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [15:0] m_pend;
    int          m_ptr;
    logic        m_valid;
    int          m_idx;
    logic        m_ovf;

    event_encoder_16x4 dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .out_ready (out_ready),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ovf   = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the inputs as they
    // stood just before the edge.
    task automatic model_edge();
        bit          xfer;
        bit          loaded;
        int          k;
        bit          lost;
        logic [15:0] nxt;
        xfer   = m_valid && out_ready;
        loaded = 0;
        k      = 0;
        if ((!m_valid || xfer) && m_pend != 0) begin
            for (int j = 0; j < 16; j++) begin
                int c;
                c = (m_ptr + j) % 16;
                if (!loaded && m_pend[c]) begin
                    loaded = 1;
                    k      = c;
                end
            end
        end
        nxt = m_pend;
        if (loaded) nxt[k] = 1'b0;
        lost = 0;
        for (int i = 0; i < 16; i++) begin
            if (en && req[i] && nxt[i]) lost = 1;
            if (en && req[i]) nxt[i] = 1'b1;
        end
        m_pend = nxt;
        if (lost) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (loaded) begin
            m_valid = 1'b1;
            m_idx   = k;
            m_ptr   = (k + 1) % 16;
        end else if (xfer) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".valid"},   32'(out_valid), 32'(m_valid));
        if (m_valid) check({tag, ".idx"}, 32'(out_idx), 32'(m_idx));
        check({tag, ".pending"}, 32'(pending),   32'(m_pend));
        check({tag, ".ovf"},     32'(overflow),  32'(m_ovf));
        check({tag, ".ptr"},     32'(dut.ptr_q), 32'(m_ptr));
    endtask

    // Advance one clock, update the model, then compare just after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        compare_model(tag);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        model_reset();

        // Reset state
        tick("reset0");
        tick("reset1");
        check("reset.valid", 32'(out_valid), 32'd0);
        check("reset.pend",  32'(pending),   32'd0);
        rst = 1'b0;

        // Single event on source 3
        en = 1'b1; req = 16'h0008; out_ready = 1'b1;
        tick("single.e0");
        check("single.e0.valid", 32'(out_valid), 32'd0);
        req = '0;
        tick("single.e1");
        check("single.e1.valid", 32'(out_valid), 32'd1);
        check("single.e1.idx",   32'(out_idx),   32'd3);
        check("single.e1.pend",  32'(pending),   32'h0000);
        tick("single.e2");
        check("single.e2.valid", 32'(out_valid), 32'd0);

        // Backpressure with two simultaneous events
        out_ready = 1'b0; req = 16'h0006;
        tick("bp.cap");
        req = '0;
        tick("bp.load");
        check("bp.idx1",  32'(out_idx), 32'd1);
        check("bp.pend",  32'(pending), 32'h0004);
        for (int i = 0; i < 3; i++) begin
            tick("bp.hold");
            check("bp.hold.valid", 32'(out_valid), 32'd1);
            check("bp.hold.idx",   32'(out_idx),   32'd1);
        end
        out_ready = 1'b1;
        tick("bp.x1");
        check("bp.x1.idx", 32'(out_idx), 32'd2);
        tick("bp.x2");
        check("bp.x2.valid", 32'(out_valid), 32'd0);

        // Wrap-around: serve 14, then 15 and 0 in that order
        req = 16'h4000;
        tick("wrap.cap14");
        req = '0;
        tick("wrap.load14");
        check("wrap.idx14", 32'(out_idx), 32'd14);
        req = 16'h8001;
        tick("wrap.cap");
        req = '0;
        tick("wrap.load15");
        check("wrap.idx15", 32'(out_idx), 32'd15);
        tick("wrap.load0");
        check("wrap.idx0", 32'(out_idx), 32'd0);
        check("wrap.ptr",  32'(dut.ptr_q), 32'd1);
        tick("wrap.drain");

        // Overflow: slot held on index 0, source 5 strobed twice
        out_ready = 1'b0; req = 16'h0001;
        tick("ovf.cap0");
        req = 16'h0020;
        tick("ovf.req5a");
        check("ovf.first.flag", 32'(overflow), 32'd0);
        tick("ovf.req5b");
        check("ovf.flag", 32'(overflow), 32'd1);
        req = '0; clr_ovf = 1'b1;
        tick("ovf.clr");
        check("ovf.cleared", 32'(overflow), 32'd0);
        clr_ovf = 1'b0; out_ready = 1'b1;
        tick("ovf.drain0");
        tick("ovf.drain1");
        tick("ovf.drain2");

        // Enable gating, then reset in the middle of a cycle
        out_ready = 1'b0; req = 16'h0100;
        tick("en.cap8");
        req = 16'h00F0;
        tick("en.capF0");
        en = 1'b0; req = 16'hFFFF;
        tick("en.off0");
        tick("en.off1");
        check("en.off.pend",  32'(pending),   32'h00F0);
        check("en.off.valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst.async.valid", 32'(out_valid), 32'd0);
        check("rst.async.idx",   32'(out_idx),   32'd0);
        check("rst.async.pend",  32'(pending),   32'd0);
        check("rst.async.ovf",   32'(overflow),  32'd0);
        check("rst.async.ptr",   32'(dut.ptr_q), 32'd0);
        en = 1'b1; clr_ovf = 1'b1; out_ready = 1'b1;
        tick("rst.held");
        check("rst.held.pend", 32'(pending), 32'd0);
        rst = 1'b0; clr_ovf = 1'b0; req = 16'h0010;
        tick("rst.firstcap");
        check("rst.firstcap.pend", 32'(pending), 32'h0010);
        req = '0;
        tick("rst.load");
        check("rst.load.idx", 32'(out_idx), 32'd4);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       req = 16'($urandom);
                1:       req = 16'($urandom) & 16'($urandom) & 16'($urandom);
                2:       req = 16'(1) << $urandom_range(0, 15);
                default: req = '0;
            endcase
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_event_encoder_16x4
